// File: rtl/rv32im_br_unit_pkg.sv
// Shared widths, branch opcode encodings and the taken-decision helper
// for the branch-resolution unit.
package rv32im_br_unit_pkg;

    localparam int API_ADDR_WIDTH  = 32;
    localparam int API_DATA_WIDTH  = 32;
    localparam int BR_OPCODE_WIDTH = 3;

    localparam logic [API_ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000;

    // funct3-aligned branch/jump selectors
    typedef enum logic [BR_OPCODE_WIDTH-1:0] {
        BR_OPCODE_BEQ  = 3'b000,
        BR_OPCODE_BNE  = 3'b001,
        BR_OPCODE_JAL  = 3'b010,
        BR_OPCODE_JALR = 3'b011,
        BR_OPCODE_BLT  = 3'b100,
        BR_OPCODE_BGE  = 3'b101,
        BR_OPCODE_BLTU = 3'b110,
        BR_OPCODE_BGEU = 3'b111
    } br_opcode_e;

    // Conditional-branch decision from the ALU zero flag. For BLT/BLTU the
    // ALU produces SLT/SLTU, so zero means "not less"; BGE/BGEU invert that.
    function automatic logic cond_taken(input logic [BR_OPCODE_WIDTH-1:0] opcode,
                                        input logic                       zero);
        logic taken;
        taken = 1'b0;
        case (opcode)
            BR_OPCODE_BEQ:  taken = zero;
            BR_OPCODE_BNE:  taken = ~zero;
            BR_OPCODE_BLT:  taken = ~zero;
            BR_OPCODE_BLTU: taken = ~zero;
            BR_OPCODE_BGE:  taken = zero;
            BR_OPCODE_BGEU: taken = zero;
            default:        taken = 1'b0;  // JAL/JALR encodings are never conditional
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/rv32im_br_unit_cond.sv
// Combinational taken decision, target address and next-PC selection.
module rv32im_br_unit_cond
    import rv32im_br_unit_pkg::*;
(
    input  logic                       alu_zero_i,
    input  logic                       br_en_i,
    input  logic                       br_conditional_i,
    input  logic [API_ADDR_WIDTH-1:0]  exu_calc_addr,
    input  logic [BR_OPCODE_WIDTH-1:0] br_opcode_i,
    input  logic [API_ADDR_WIDTH-1:0]  curr_pc_i,
    input  logic [API_DATA_WIDTH-1:0]  imm_i,
    output logic                       taken_o,
    output logic [API_ADDR_WIDTH-1:0]  target_o,
    output logic [API_ADDR_WIDTH-1:0]  nxt_pc_o
);

    logic                      is_jalr;
    logic signed [API_DATA_WIDTH-1:0] imm_s;

    // Resolve taken, target and fallthrough; target is produced every cycle
    always_comb begin
        imm_s   = signed'(imm_i);
        is_jalr = ~br_conditional_i && (br_opcode_i == BR_OPCODE_JALR);

        // JALR clears bit 0 of the EXU address; everything else is PC-relative
        if (is_jalr)
            target_o = exu_calc_addr & ~API_ADDR_WIDTH'(1);
        else
            target_o = curr_pc_i + unsigned'(imm_s);

        if (!br_en_i)
            taken_o = 1'b0;
        else if (!br_conditional_i)
            taken_o = 1'b1;
        else
            taken_o = cond_taken(br_opcode_i, alu_zero_i);

        nxt_pc_o = taken_o ? target_o : curr_pc_i + API_ADDR_WIDTH'(4);
    end

endmodule

// File: rtl/rv32im_br_unit.sv
// Branch-resolution unit: registers the branch target and next fetch PC
// one cycle after the execute-stage inputs are presented.
module rv32im_br_unit
    import rv32im_br_unit_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alu_zero_i,
    input  logic                       br_en_i,
    input  logic                       br_conditional_i,
    input  logic [API_ADDR_WIDTH-1:0]  exu_calc_addr,
    input  logic [BR_OPCODE_WIDTH-1:0] br_opcode_i,
    input  logic [API_ADDR_WIDTH-1:0]  curr_pc_i,
    input  logic [API_DATA_WIDTH-1:0]  imm_i,
    output logic [API_ADDR_WIDTH-1:0]  br_pc_o,
    output logic [API_ADDR_WIDTH-1:0]  nxt_pc_o
);

    logic                      taken_p0;
    logic [API_ADDR_WIDTH-1:0] target_p0;
    logic [API_ADDR_WIDTH-1:0] nxt_pc_p0;
    logic [API_ADDR_WIDTH-1:0] br_pc_p1;
    logic [API_ADDR_WIDTH-1:0] nxt_pc_p1;

    // ---- stage p0: combinational resolution ----
    rv32im_br_unit_cond u_cond (
        .alu_zero_i       (alu_zero_i),
        .br_en_i          (br_en_i),
        .br_conditional_i (br_conditional_i),
        .exu_calc_addr    (exu_calc_addr),
        .br_opcode_i      (br_opcode_i),
        .curr_pc_i        (curr_pc_i),
        .imm_i            (imm_i),
        .taken_o          (taken_p0),
        .target_o         (target_p0),
        .nxt_pc_o         (nxt_pc_p0)
    );

    // ---- stage p1: output registers; reset forces the fetch to the reset vector ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            br_pc_p1  <= '0;
            nxt_pc_p1 <= RESET_VECTOR;
        end else begin
            br_pc_p1  <= target_p0;
            nxt_pc_p1 <= nxt_pc_p0;
        end
    end

    assign br_pc_o  = br_pc_p1;
    assign nxt_pc_o = nxt_pc_p1;

endmodule

// File: tb/tb_rv32im_br_unit.sv
// Bench for rv32im_br_unit: directed cases plus randomized traffic
// compared against a behavioural model of the branch rules.
module tb_rv32im_br_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        alu_zero_i = 1'b0;
    logic        br_en_i = 1'b0;
    logic        br_conditional_i = 1'b0;
    logic [31:0] exu_calc_addr = '0;
    logic [2:0]  br_opcode_i = '0;
    logic [31:0] curr_pc_i = '0;
    logic [31:0] imm_i = '0;
    logic [31:0] br_pc_o;
    logic [31:0] nxt_pc_o;

    int total = 0;
    int bad   = 0;

    rv32im_br_unit dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .alu_zero_i       (alu_zero_i),
        .br_en_i          (br_en_i),
        .br_conditional_i (br_conditional_i),
        .exu_calc_addr    (exu_calc_addr),
        .br_opcode_i      (br_opcode_i),
        .curr_pc_i        (curr_pc_i),
        .imm_i            (imm_i),
        .br_pc_o          (br_pc_o),
        .nxt_pc_o         (nxt_pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: returns {br_pc, nxt_pc} from the current input values
    function automatic logic [63:0] ref_model();
        logic [31:0] tgt;
        logic [31:0] nxt;
        bit          tk;
        if (!br_conditional_i && br_opcode_i == 3'd3)
            tgt = exu_calc_addr & 32'hFFFF_FFFE;
        else
            tgt = curr_pc_i + imm_i;
        if (!br_en_i)
            tk = 0;
        else if (!br_conditional_i)
            tk = 1;
        else begin
            case (br_opcode_i)
                3'd0:    tk = alu_zero_i;    // BEQ
                3'd1:    tk = !alu_zero_i;   // BNE
                3'd4:    tk = !alu_zero_i;   // BLT  (SLT=1 -> not zero)
                3'd6:    tk = !alu_zero_i;   // BLTU
                3'd5:    tk = alu_zero_i;    // BGE
                3'd7:    tk = alu_zero_i;    // BGEU
                default: tk = 0;             // JAL/JALR codes in conditional mode
            endcase
        end
        nxt = tk ? tgt : curr_pc_i + 32'd4;
        return {tgt, nxt};
    endfunction

    // Drive at the falling edge, sample 1 time unit after the rising edge
    task automatic step(input string tag, input logic en, input logic cond, input logic zero,
                        input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] exu);
        logic [63:0] exp;
        @(negedge clk_i);
        br_en_i = en; br_conditional_i = cond; alu_zero_i = zero;
        br_opcode_i = op; curr_pc_i = pc; imm_i = imm; exu_calc_addr = exu;
        exp = ref_model();
        @(posedge clk_i);
        #1;
        check_eq({tag, "_br"}, br_pc_o, exp[63:32]);
        check_eq({tag, "_nxt"}, nxt_pc_o, exp[31:0]);
    endtask

    initial begin
        logic [63:0] exp;

        // Power-on reset: outputs forced immediately and held across edges
        #2;
        check_eq("por_br", br_pc_o, 32'h0);
        check_eq("por_nxt", nxt_pc_o, 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("por_hold_br", br_pc_o, 32'h0);
        check_eq("por_hold_nxt", nxt_pc_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // BEQ not taken / taken with wrapping-free carry into bit 21
        step("beq_nt", 1, 1, 0, 3'd0, 32'h001F_FFF3, 32'd15, 32'h0);
        check_eq("beq_nt_br_k", br_pc_o, 32'h0020_0002);
        check_eq("beq_nt_nxt_k", nxt_pc_o, 32'h001F_FFF7);
        step("beq_tk", 1, 1, 1, 3'd0, 32'h001F_FFF3, 32'd15, 32'h0);
        check_eq("beq_tk_nxt_k", nxt_pc_o, 32'h0020_0002);

        // Every opcode in conditional mode with both zero polarities
        for (int op = 0; op < 8; op++) begin
            for (int z = 0; z < 2; z++) begin
                step($sformatf("cond_op%0d_z%0d", op, z), 1, 1, z[0], op[2:0],
                     32'h0000_4000, 32'h0000_0100, 32'h0000_9001);
            end
        end
        // Spot-check polarity with constants: BLT zero=0 taken, BGEU zero=0 not
        step("blt_z0", 1, 1, 0, 3'd4, 32'h1000, 32'h20, 32'h0);
        check_eq("blt_z0_k", nxt_pc_o, 32'h1020);
        step("bgeu_z0", 1, 1, 0, 3'd7, 32'h1000, 32'h20, 32'h0);
        check_eq("bgeu_z0_k", nxt_pc_o, 32'h1004);

        // Unconditional jumps
        step("jal", 1, 0, 0, 3'd2, 32'h100, 32'hFFFF_FFF0, 32'h2001);
        check_eq("jal_k", nxt_pc_o, 32'h0000_00F0);
        step("jalr", 1, 0, 1, 3'd3, 32'h100, 32'hFFFF_FFF0, 32'h2001);
        check_eq("jalr_nxt_k", nxt_pc_o, 32'h0000_2000);
        check_eq("jalr_br_k", br_pc_o, 32'h0000_2000);

        // Disabled with wrap, then enabled with wrapping target
        step("dis_wrap", 0, 1, 1, 3'd0, 32'hFFFF_FFFC, 32'd8, 32'h0);
        check_eq("dis_wrap_nxt_k", nxt_pc_o, 32'h0);
        step("en_wrap", 1, 1, 1, 3'd0, 32'hFFFF_FFFC, 32'd8, 32'h0);
        check_eq("en_wrap_br_k", br_pc_o, 32'h0000_0004);
        check_eq("en_wrap_nxt_k", nxt_pc_o, 32'h0000_0004);

        // Mid-stream asynchronous reset, away from any clock edge
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("async_rst_br", br_pc_o, 32'h0);
        check_eq("async_rst_nxt", nxt_pc_o, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            br_en_i = 1'b1; br_conditional_i = 1'b0; br_opcode_i = 3'($urandom);
            curr_pc_i = $urandom; imm_i = $urandom; exu_calc_addr = $urandom;
            @(posedge clk_i);
            #1;
            check_eq("rst_hold_br", br_pc_o, 32'h0);
            check_eq("rst_hold_nxt", nxt_pc_o, 32'h0);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        exp = ref_model();
        @(posedge clk_i);
        #1;
        check_eq("post_rst_br", br_pc_o, exp[63:32]);
        check_eq("post_rst_nxt", nxt_pc_o, exp[31:0]);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, 3'($urandom), $urandom, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
